// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the processor memory arbiter.
// The FSM state encoding and the transaction owner encoding live here.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        READ_WAIT = 2'd2,
        RESPOND   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int DEFAULT_STARVE_LIMIT = 2;

    // Bits needed to count 0..limit inclusive.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/memory_arbiter_arb_pick.sv
// Winner selection between fetch and data, with a starvation counter that
// forces a fetch grant after STARVE_LIMIT consecutive data grants.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_req,
    input  logic arb_en,
    output logic winner
);

    localparam int                CNT_W = cnt_width(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    always_comb begin
        starved = (starve_cnt == LIMIT);
        winner  = (if_req && (!d_req || starved)) ? OWN_IF : OWN_D;
    end

    // A pending fetch accumulates data grants; a withdrawn fetch owes nothing.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!if_req) begin
            starve_cnt <= '0;
        end else if (arb_en) begin
            if (winner == OWN_IF)
                starve_cnt <= '0;
            else if (!starved)
                starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Serializes instruction-fetch and data load/store requests onto the
// single-port processor memory, one transaction at a time.
module memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WORD_SIZE    = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [WORD_SIZE-1:0]  if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WORD_SIZE-1:0]  d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [WORD_SIZE-1:0]  d_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [WORD_SIZE-1:0]  mem_data,
    output logic                  mem_wren,
    input  logic [WORD_SIZE-1:0]  mem_q,
    output logic                  busy
);

    state_t                state;
    owner_t                owner;
    logic                  arb_en;
    logic                  arb_go;
    logic                  winner;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [WORD_SIZE-1:0]  win_data;
    logic                  win_we;

    // A write's GRANT cycle may launch the next transaction at once; masters
    // present their next request (or drop it) in the cycle their gnt is high.
    always_comb begin
        arb_en = 1'b0;
        unique case (state)
            IDLE, RESPOND: arb_en = 1'b1;
            GRANT:         arb_en = mem_wren;
            default:       arb_en = 1'b0;
        endcase
        arb_go   = arb_en && (if_req || d_req);
        win_addr = (winner == OWN_D) ? d_addr  : if_addr;
        win_data = (winner == OWN_D) ? d_wdata : '0;
        win_we   = (winner == OWN_D) && d_we;
    end

    arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb_pick (
        .clk    (clk),
        .rst    (rst),
        .if_req (if_req),
        .d_req  (d_req),
        .arb_en (arb_go),
        .winner (winner)
    );

    // NOTE: the memory-side and rdata registers are reset too, so nothing
    // left over from an aborted transaction is visible after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            owner       <= OWN_IF;
            if_gnt      <= 1'b0;
            d_gnt       <= 1'b0;
            if_rvalid   <= 1'b0;
            d_rvalid    <= 1'b0;
            if_rdata    <= '0;
            d_rdata     <= '0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if (arb_go) begin
                state       <= GRANT;
                busy        <= 1'b1;
                owner       <= owner_t'(winner);
                if_gnt      <= (winner == OWN_IF);
                d_gnt       <= (winner == OWN_D);
                mem_address <= win_addr;
                mem_data    <= win_data;
                mem_wren    <= win_we;
            end else begin
                unique case (state)
                    GRANT: begin
                        if (!mem_wren) begin
                            state <= READ_WAIT;
                        end else begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            mem_wren <= 1'b0;
                        end
                    end
                    READ_WAIT: begin
                        state <= RESPOND;
                        if (owner == OWN_D) begin
                            d_rdata  <= mem_q;
                            d_rvalid <= 1'b1;
                        end else begin
                            if_rdata  <= mem_q;
                            if_rvalid <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        mem_wren <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter with a behavioural
// single-port memory (one-cycle read latency) attached to the mem_* port.
module tb_memory_arbiter;

    localparam int WS = 32;
    localparam int AW = 16;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [WS-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [WS-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [WS-1:0] d_rdata;
    logic [AW-1:0] mem_address;
    logic [WS-1:0] mem_data;
    logic          mem_wren;
    logic [WS-1:0] mem_q;
    logic          busy;

    logic [WS-1:0] mem [65536];

    int n_cmp = 0;
    int n_bad = 0;

    memory_arbiter #(
        .WORD_SIZE    (WS),
        .ADDR_WIDTH   (AW),
        .STARVE_LIMIT (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_gnt      (if_gnt),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_gnt       (d_gnt),
        .d_rvalid    (d_rvalid),
        .d_rdata     (d_rdata),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wren) mem[mem_address] <= mem_data;
        mem_q <= mem[mem_address];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wren, busy} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 000000",
                     {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wren, busy});
        end
        n_cmp++;
        if ({mem_address, mem_data, if_rdata, d_rdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_regs: got addr=%h data=%h if_rdata=%h d_rdata=%h want all 0",
                     mem_address, mem_data, if_rdata, d_rdata);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch_only();
        int d_noise;
        d_noise = 0;
        if_req = 1'b1; if_addr = 16'd5;
        @(negedge clk);
        if (d_gnt || d_rvalid) d_noise++;
        n_cmp++;
        if ({if_gnt, busy, mem_wren} !== 3'b110 || mem_address !== 16'd5) begin
            n_bad++;
            $display("FAIL fetch_grant: got gnt,busy,wren=%b addr=%0d want 110 addr=5",
                     {if_gnt, busy, mem_wren}, mem_address);
        end
        if_req = 1'b0;
        @(negedge clk);
        if (d_gnt || d_rvalid) d_noise++;
        n_cmp++;
        if ({if_gnt, if_rvalid, busy, mem_wren} !== 4'b0010) begin
            n_bad++;
            $display("FAIL fetch_wait: got gnt,rvalid,busy,wren=%b want 0010",
                     {if_gnt, if_rvalid, busy, mem_wren});
        end
        @(negedge clk);
        if (d_gnt || d_rvalid) d_noise++;
        n_cmp++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h1234) begin
            n_bad++;
            $display("FAIL fetch_data: got rvalid=%b rdata=%h want 1 00001234",
                     if_rvalid, if_rdata);
        end
        @(negedge clk);
        if (d_gnt || d_rvalid) d_noise++;
        n_cmp++;
        if ({if_rvalid, busy} !== 2'b00 || d_noise !== 0 || d_rdata !== '0) begin
            n_bad++;
            $display("FAIL fetch_quiet: got rvalid,busy=%b d_noise=%0d d_rdata=%h want 00 0 0",
                     {if_rvalid, busy}, d_noise, d_rdata);
        end
    endtask

    task automatic test_write_read();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'd7; d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        n_cmp++;
        if ({d_gnt, if_gnt, mem_wren} !== 3'b101 || mem_address !== 16'd7 ||
            mem_data !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL wr_grant: got gnt_d,gnt_if,wren=%b addr=%0d data=%h want 101 7 deadbeef",
                     {d_gnt, if_gnt, mem_wren}, mem_address, mem_data);
        end
        // Present the read in the write's grant cycle: next grant follows directly.
        d_we = 1'b0; d_wdata = '0;
        @(negedge clk);
        n_cmp++;
        if ({d_gnt, mem_wren, busy} !== 3'b101 || mem[7] !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL rd_grant: got gnt,wren,busy=%b mem7=%h want 101 deadbeef",
                     {d_gnt, mem_wren, busy}, mem[7]);
        end
        d_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({d_gnt, d_rvalid, mem_wren} !== 3'b000) begin
            n_bad++;
            $display("FAIL rd_wait: got gnt,rvalid,wren=%b want 000", {d_gnt, d_rvalid, mem_wren});
        end
        @(negedge clk);
        n_cmp++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF || if_rvalid !== 1'b0 ||
            mem_wren !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_data: got rvalid=%b rdata=%h if_rvalid=%b wren=%b want 1 deadbeef 0 0",
                     d_rvalid, d_rdata, if_rvalid, mem_wren);
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        int order [6];
        int gcyc [6];
        int exp_order [6];
        int n;
        int both;
        exp_order = '{1, 1, 0, 1, 1, 0};
        n = 0;
        both = 0;
        if_req = 1'b1; if_addr = 16'd30;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'd20;
        for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
            @(negedge clk);
            if (if_gnt && d_gnt) both++;
            if (if_gnt || d_gnt) begin
                order[n] = d_gnt ? 1 : 0;
                gcyc[n]  = cyc;
                n++;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        n_cmp++;
        if (n !== 6 || both !== 0) begin
            n_bad++;
            $display("FAIL cont_count: got grants=%0d overlaps=%0d want 6 0", n, both);
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (order[i] !== exp_order[i]) begin
                    n_bad++;
                    $display("FAIL cont_order[%0d]: got %s want %s", i,
                             order[i] ? "D" : "IF", exp_order[i] ? "D" : "IF");
                end
            end
            for (int i = 1; i < 6; i++) begin
                n_cmp++;
                if (gcyc[i] - gcyc[i-1] !== 3) begin
                    n_bad++;
                    $display("FAIL cont_gap[%0d]: got %0d want 3", i, gcyc[i] - gcyc[i-1]);
                end
            end
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL cont_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int idle_seen;
        idle_seen = 0;
        if_req = 1'b1; if_addr = 16'd5;
        @(negedge clk);
        n_cmp++;
        if (if_gnt !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_if_gnt: got %b want 1", if_gnt);
        end
        if_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'd9;
        @(negedge clk);
        if (!busy) idle_seen++;
        @(negedge clk);
        if (!busy) idle_seen++;
        n_cmp++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h1234 || d_gnt !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_if_resp: got rvalid=%b rdata=%h d_gnt=%b want 1 00001234 0",
                     if_rvalid, if_rdata, d_gnt);
        end
        @(negedge clk);
        if (!busy) idle_seen++;
        n_cmp++;
        if (d_gnt !== 1'b1 || mem_address !== 16'd9) begin
            n_bad++;
            $display("FAIL b2b_d_gnt: got gnt=%b addr=%0d want 1 9", d_gnt, mem_address);
        end
        d_req = 1'b0;
        @(negedge clk);
        if (!busy) idle_seen++;
        @(negedge clk);
        n_cmp++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h0BADF00D || idle_seen !== 0 ||
            if_rdata !== 32'h1234) begin
            n_bad++;
            $display("FAIL b2b_d_resp: got rvalid=%b rdata=%h idle=%0d if_rdata=%h want 1 0badf00d 0 00001234",
                     d_rvalid, d_rdata, idle_seen, if_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        int stray;
        stray = 0;
        if_req = 1'b1; if_addr = 16'd5;
        @(negedge clk);
        if_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || if_gnt !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_pre: got busy=%b gnt=%b want 1 0", busy, if_gnt);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wren, busy} !== 6'b0 ||
            {mem_address, mem_data, if_rdata, d_rdata} !== '0) begin
            n_bad++;
            $display("FAIL rstmid_async: got flags=%b addr=%h data=%h if_rdata=%h d_rdata=%h want all 0",
                     {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wren, busy},
                     mem_address, mem_data, if_rdata, d_rdata);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (if_rvalid || d_rvalid || busy) stray++;
        end
        n_cmp++;
        if (stray !== 0) begin
            n_bad++;
            $display("FAIL rstmid_stray: got %0d active cycles want 0", stray);
        end
        if_req = 1'b1; if_addr = 16'd9;
        @(negedge clk);
        if_req = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h0BADF00D) begin
            n_bad++;
            $display("FAIL rstmid_fresh: got rvalid=%b rdata=%h want 1 0badf00d", if_rvalid, if_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_withdraw();
        int d_grants;
        int wrens;
        d_grants = 0;
        wrens = 0;
        if_req = 1'b1; if_addr = 16'd5;
        @(negedge clk);
        if_req = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'd40; d_wdata = 32'hCAFEF00D;
        @(negedge clk);
        d_req = 1'b0;
        if (d_gnt) d_grants++;
        @(negedge clk);
        n_cmp++;
        if (if_rvalid !== 1'b1) begin
            n_bad++;
            $display("FAIL wd_if_resp: got rvalid=%b want 1", if_rvalid);
        end
        for (int i = 0; i < 6; i++) begin
            if (d_gnt) d_grants++;
            if (mem_wren) wrens++;
            @(negedge clk);
        end
        n_cmp++;
        if (d_grants !== 0 || wrens !== 0 || mem[40] !== '0) begin
            n_bad++;
            $display("FAIL wd_no_grant: got d_gnt=%0d wren=%0d mem40=%h want 0 0 0",
                     d_grants, wrens, mem[40]);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        mem[5] = 32'h0000_1234;
        mem[9] = 32'h0BAD_F00D;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        rst = 1'b0;
        test_reset();
        test_fetch_only();
        test_write_read();
        test_contention();
        test_back_to_back();
        test_reset_mid_read();
        test_withdraw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
